ft_alu_retry_pipe: RTL and testbench



---
 rtl/ft_alu_pkg.sv | 37 +++
 rtl/ft_adder_checker.sv | 59 +++++
 rtl/ft_alu_retry_pipe.sv | 167 ++++++++++++++++
 tb/tb_ft_alu_retry_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ft_alu_pkg.sv
// +------------------------------------------------------------------+
// | ft_alu_pkg : opcodes, FSM encoding, err_flags indices, helpers    |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

package ft_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_INC  = 4'd8;
  localparam logic [3:0] OP_DEC  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;
  localparam logic [3:0] OP_ZERO = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int ERR_PARITY = 0;
  localparam int ERR_RES3   = 1;
  localparam int ERR_CARRY  = 2;

  // Weight of the carry-out in the mod-3 residue domain: 2^W mod 3.
  function automatic logic [1:0] pow2_mod3(input int unsigned width);
    return (width % 2 == 0) ? 2'd1 : 2'd2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ft_adder_checker.sv
// +------------------------------------------------------------------+
// | ft_adder_checker : ripple adder with parity/residue/carry checks  |
// | Optional FT_ALU_FAULT_INJECT_EN adds inject_mask on the sum bits  |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

module ft_adder_checker
  import ft_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
`ifdef FT_ALU_FAULT_INJECT_EN
  input  logic [WIDTH-1:0] inject_mask,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH:0]   carry,
  output logic [2:0]       err_flags
);

  localparam logic [1:0] K_RES = pow2_mod3(WIDTH);

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] carry_exp;
  logic [1:0]       res_sum, res_a, res_b, res_lhs, res_rhs;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    assign raw_sum[i]   = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    assign carry_exp[i] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

`ifdef FT_ALU_FAULT_INJECT_EN
  assign sum = raw_sum ^ inject_mask;
`else
  assign sum = raw_sum;
`endif

  assign cout = carry[WIDTH];

  assign res_sum = 2'(sum % WIDTH'(3));
  assign res_a   = 2'(a % WIDTH'(3));
  assign res_b   = 2'(b % WIDTH'(3));
  assign res_lhs = 2'((3'(res_sum) + (cout ? 3'(K_RES) : 3'd0)) % 3'd3);
  assign res_rhs = 2'((3'(res_a) + 3'(res_b) + 3'(cin)) % 3'd3);

  assign err_flags[ERR_PARITY] = (^sum) != ((^a) ^ (^b) ^ (^carry[WIDTH-1:0]));
  assign err_flags[ERR_RES3]   = res_lhs != res_rhs;
  assign err_flags[ERR_CARRY]  = |(carry[WIDTH:1] ^ carry_exp);

endmodule

`default_nettype wire

// File: rtl/ft_alu_retry_pipe.sv
// +------------------------------------------------------------------+
// | ft_alu_retry_pipe : checked ALU with bounded re-execution         |
// | Optional FT_ALU_FAULT_INJECT_EN adds the inject_mask input        |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
`default_nettype none

module ft_alu_retry_pipe
  import ft_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FT_ALU_FAULT_INJECT_EN
  input  logic [WIDTH-1:0] inject_mask,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic [2:0]       err_flags,
  output logic             retried,
  output logic             fatal,
  output logic [CNT_W-1:0] err_count
);

  localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [RC_W-1:0]  retry_cnt;
  logic             retried_q, fatal_q;

  logic [WIDTH-1:0] add_b, sum, alu_res;
  logic             add_cin, add_cout, alu_cout, alu_ovf;
  logic [WIDTH:0]   chain;
  logic [2:0]       chk_flags, flags;
  logic             is_add, err_det;
  logic             unused_chain;

  always_comb begin
    add_b   = b_q;
    add_cin = 1'b0;
    case (op_q)
      OP_SUB:  begin add_b = ~b_q; add_cin = 1'b1; end
      OP_INC:  begin add_b = '0;   add_cin = 1'b1; end
      OP_DEC:  add_b = '1;
      default: ;
    endcase
  end

  ft_adder_checker #(.WIDTH(WIDTH)) u_adder (
`ifdef FT_ALU_FAULT_INJECT_EN
    .inject_mask (inject_mask),
`endif
    .a           (a_q),
    .b           (add_b),
    .cin         (add_cin),
    .sum         (sum),
    .cout        (add_cout),
    .carry       (chain),
    .err_flags   (chk_flags)
  );

  assign unused_chain = ^chain;

  assign is_add  = op_q inside {OP_ADD, OP_SUB, OP_INC, OP_DEC};
  assign flags   = is_add ? chk_flags : 3'b000;
  assign err_det = |flags;

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin alu_res = sum; alu_cout = add_cout; end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOT:  alu_res = ~a_q;
      OP_SHL:  begin alu_res = {a_q[WIDTH-2:0], 1'b0}; alu_cout = a_q[WIDTH-1]; end
      OP_SHR:  begin alu_res = {1'b0, a_q[WIDTH-1:1]}; alu_cout = a_q[0]; end
      OP_PASS: alu_res = a_q;
      default: ;
    endcase
    if (op_q == OP_ADD)
      alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
    else if (op_q == OP_SUB)
      alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      retry_cnt <= '0;
      retried_q <= 1'b0;
      fatal_q   <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      err_flags <= '0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q       <= op_a;
            b_q       <= op_b;
            op_q      <= opcode;
            retry_cnt <= '0;
            retried_q <= 1'b0;
            fatal_q   <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (err_det && (retry_cnt < RC_W'(MAX_RETRY))) begin
            retry_cnt <= retry_cnt + 1'b1;
            retried_q <= 1'b1;
          end else begin
            result    <= alu_res;
            cout      <= alu_cout;
            zero      <= (alu_res == '0);
            overflow  <= alu_ovf;
            err_flags <= flags;
            fatal_q   <= err_det;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            retried_q <= 1'b0;
            fatal_q   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Every erroneous attempt counts, including the one that goes fatal.
      if ((state == ST_EXEC) && err_det && (err_count != '1))
        err_count <= err_count + 1'b1;
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign retried   = retried_q & out_valid;
  assign fatal     = fatal_q & out_valid;

endmodule

`default_nettype wire

// File: tb/tb_ft_alu_retry_pipe.sv
// +------------------------------------------------------------------+
// | tb_ft_alu_retry_pipe : directed vectors for ft_alu_retry_pipe     |
// | Revision 1.0                                                      |
// +------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_ft_alu_retry_pipe;

  localparam int W  = 32;
  localparam int WS = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, out_ready;
  logic [W-1:0]  op_a, op_b, inject_mask;
  logic [3:0]    opcode;
  logic          in_ready, out_valid, cout, zero, overflow, retried, fatal;
  logic [W-1:0]  result;
  logic [2:0]    err_flags;
  logic [7:0]    err_count;

  logic          in_valid_s, out_ready_s;
  logic [WS-1:0] op_a_s, op_b_s, inject_mask_s, result_s;
  logic [3:0]    opcode_s;
  logic          in_ready_s, out_valid_s, cout_s, zero_s, overflow_s, retried_s, fatal_s;
  logic [2:0]    err_flags_s;
  logic [7:0]    err_count_s;

  ft_alu_retry_pipe #(.WIDTH(W), .MAX_RETRY(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
`ifdef FT_ALU_FAULT_INJECT_EN
    .inject_mask(inject_mask),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout), .zero(zero),
    .overflow(overflow), .err_flags(err_flags), .retried(retried), .fatal(fatal),
    .err_count(err_count)
  );

  ft_alu_retry_pipe #(.WIDTH(WS), .MAX_RETRY(2), .CNT_W(8)) dut17 (
    .clk(clk), .rst(rst),
`ifdef FT_ALU_FAULT_INJECT_EN
    .inject_mask(inject_mask_s),
`endif
    .in_valid(in_valid_s), .in_ready(in_ready_s), .op_a(op_a_s), .op_b(op_b_s), .opcode(opcode_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .result(result_s), .cout(cout_s), .zero(zero_s),
    .overflow(overflow_s), .err_flags(err_flags_s), .retried(retried_s), .fatal(fatal_s),
    .err_count(err_count_s)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // inj_cycles = number of leading EXEC cycles that see inject_mask = 0x4.
  task automatic run_op(input logic [3:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj_cycles, output int lat);
    int cyc;
    opcode   = opc;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    lat         = 1;
    cyc         = 1;
    inject_mask = (cyc <= inj_cycles) ? W'(4) : '0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      cyc++;
      inject_mask = (cyc <= inj_cycles) ? W'(4) : '0;
    end
    inject_mask = '0;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic vec(input string tag, input logic [3:0] opc, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] res,
                     input logic c, input logic z, input logic v);
    int lat;
    run_op(opc, a, b, 0, lat);
    check({tag, ".lat"}, 64'(lat), 64'd2);
    check({tag, ".res"}, 64'(result), 64'(res));
    check({tag, ".cout"}, 64'(cout), 64'(c));
    check({tag, ".zero"}, 64'(zero), 64'(z));
    check({tag, ".ovf"}, 64'(overflow), 64'(v));
    check({tag, ".flags"}, 64'(err_flags), 64'd0);
    check({tag, ".retried"}, 64'(retried), 64'd0);
    check({tag, ".fatal"}, 64'(fatal), 64'd0);
    take_result();
  endtask

  task automatic run17(input string tag, input logic [3:0] opc, input logic [WS-1:0] a,
                       input logic [WS-1:0] b, input logic [WS-1:0] res, input logic c);
    int lat;
    opcode_s   = opc;
    op_a_s     = a;
    op_b_s     = b;
    in_valid_s = 1'b1;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    lat = 1;
    while (!out_valid_s && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'd2);
    check({tag, ".res"}, 64'(result_s), 64'(res));
    check({tag, ".cout"}, 64'(cout_s), 64'(c));
    check({tag, ".flags"}, 64'(err_flags_s), 64'd0);
    check({tag, ".errcnt"}, 64'(err_count_s), 64'd0);
    out_ready_s = 1'b1;
    @(posedge clk); #1;
    out_ready_s = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] held;
    int           lat;

    in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; opcode = '0; inject_mask = '0;
    in_valid_s = 1'b0; out_ready_s = 1'b0; op_a_s = '0; op_b_s = '0; opcode_s = '0;
    inject_mask_s = '0;
    do_reset();

    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.err_count", 64'(err_count), 64'd0);
    check("rst.fatal", 64'(fatal), 64'd0);

    vec("add_wrap", 4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    vec("sub_ovf",  4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1);
    vec("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    vec("sub_eq",   4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    vec("and",      4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    vec("or",       4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    vec("xor",      4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0);
    vec("not",      4'd5,  32'h1234_5678, 32'h0000_0000, 32'hEDCB_A987, 1'b0, 1'b0, 1'b0);
    vec("shl",      4'd6,  32'h8000_0001, 32'h0000_0000, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    vec("shr",      4'd7,  32'h0000_0003, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    vec("inc",      4'd8,  32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    vec("inc_wrap", 4'd8,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    vec("dec",      4'd9,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    vec("pass",     4'd10, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    vec("zero",     4'd11, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    vec("op15",     4'd15, 32'h0000_FFFF, 32'h1111_1111, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    check("clean.err_count", 64'(err_count), 64'd0);

    // Back-pressure: result held, in_ready low until after the handshake edge.
    run_op(4'd0, 32'h0000_1234, 32'h0000_4321, 0, lat);
    held = result;
    check("bp.res", 64'(held), 64'h5555);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp.hold_res", 64'(result), 64'(held));
      check("bp.hold_valid", 64'(out_valid), 64'd1);
      check("bp.hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1 check("bp.ready_at_hs", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp.ready_after", 64'(in_ready), 64'd1);
    check("bp.valid_after", 64'(out_valid), 64'd0);

`ifdef FT_ALU_FAULT_INJECT_EN
    do_reset();
    run_op(4'd0, 32'h0000_0010, 32'h0000_0020, 1, lat);
    check("inj1.lat", 64'(lat), 64'd3);
    check("inj1.res", 64'(result), 64'h30);
    check("inj1.errcnt", 64'(err_count), 64'd1);
    check("inj1.retried", 64'(retried), 64'd1);
    check("inj1.fatal", 64'(fatal), 64'd0);
    check("inj1.flags", 64'(err_flags), 64'd0);
    take_result();
    check("inj1.retried_clr", 64'(retried), 64'd0);

    do_reset();
    run_op(4'd0, 32'h0000_0010, 32'h0000_0020, 99, lat);
    check("injall.lat", 64'(lat), 64'd4);
    check("injall.res", 64'(result), 64'h34);
    check("injall.errcnt", 64'(err_count), 64'd3);
    check("injall.retried", 64'(retried), 64'd1);
    check("injall.fatal", 64'(fatal), 64'd1);
    check("injall.flags", 64'(err_flags), 64'b011);
    take_result();
    check("injall.fatal_clr", 64'(fatal), 64'd0);
`endif

    // Reset while EXEC aborts the operation.
    opcode = 4'd0; op_a = 32'h0000_0001; op_b = 32'h0000_0002; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rexec.in_exec", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rexec.in_ready", 64'(in_ready), 64'd1);
    check("rexec.out_valid", 64'(out_valid), 64'd0);
    check("rexec.err_count", 64'(err_count), 64'd0);
    check("rexec.result", 64'(result), 64'd0);
    repeat (3) @(posedge clk);
    #1 check("rexec.no_output", 64'(out_valid), 64'd0);

    run17("w17.add", 4'd0, 17'h1FFFF, 17'h00001, 17'h00000, 1'b1);
    check("w17.zero", 64'(zero_s), 64'd1);
    run17("w17.sub", 4'd1, 17'h00000, 17'h00001, 17'h1FFFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
